// File: rtl/vliw_bundle_packer.sv
// vliw_bundle_packer
//   Packs a stream of scalar ALU ops into 2-slot 32-bit VLIW bundles.
//   Two consecutive ops are paired when their destinations differ.
//   Otherwise the older op goes out alone, with slot 2 duplicating slot 1,
//   so that the second regfile write rewrites the same value.
//   Bundle: [31:24] op1, [23:16] op2, [15:12] dst1, [11:8] dst2, [7:0] 0.
//
// Optional feature: define VLIW_PACK_TIMEOUT_EN to emit a lone pending op
//   after FLUSH_CYCLES consecutive HOLD cycles without an accept.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      scalar op handshake (in_op[7:0], in_dst[3:0])
//   flush                  level; force out the pending op
//   out_valid/out_ready    bundle handshake (out_bundle[31:0])
//   err_illegal            1-cycle pulse: illegal opcode accepted and dropped
//   busy                   pending op held or bundle waiting
module vliw_bundle_packer #(
   parameter int FLUSH_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_op,
   input  logic [3:0]  in_dst,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_bundle,
   output logic        err_illegal,
   output logic        busy
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_bad_flush_cycles
      $error("FLUSH_CYCLES must be in 1..255");
   end

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_op_q, a_op_d;
   logic [3:0]  a_dst_q, a_dst_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_bundle_q, out_bundle_d;
   logic        err_q, err_d;

   logic out_free, accept, legal, timeout;

   assign out_free = !out_valid_q || out_ready;
   // in_ready is held low during reset; in HOLD a flush takes the cycle.
   assign in_ready = rst_n && ((state_q == IDLE) || (out_free && !flush));
   assign accept   = in_valid && in_ready;
   assign legal    = (in_op <= 8'h05);

`ifdef VLIW_PACK_TIMEOUT_EN
   logic [7:0] timer_q;
   logic [8:0] timer_inc;

   assign timer_inc = {1'b0, timer_q} + 9'd1;
   // Fires on the cycle whose closing edge brings the count to FLUSH_CYCLES,
   // and keeps firing while the count sits saturated behind a busy output.
   assign timeout   = (state_q == HOLD) && !accept &&
                      (timer_inc >= 9'(FLUSH_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= 8'h00;
      end else if (state_q != HOLD || accept || state_d != HOLD) begin
         timer_q <= 8'h00;
      end else if ({1'b0, timer_q} < 9'(FLUSH_CYCLES)) begin
         timer_q <= timer_inc[7:0];
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      a_op_d       = a_op_q;
      a_dst_d      = a_dst_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_bundle_d = out_bundle_q;
      err_d        = accept && !legal;

      unique case (state_q)
         IDLE: begin
            if (accept && legal) begin
               a_op_d  = in_op;
               a_dst_d = in_dst;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (flush && out_free) begin
               out_valid_d  = 1'b1;
               out_bundle_d = {a_op_q, a_op_q, a_dst_q, a_dst_q, 8'h00};
               state_d      = IDLE;
            end else if (accept && legal) begin
               // accept in HOLD already implies the output register is free
               out_valid_d = 1'b1;
               if (in_dst != a_dst_q) begin
                  out_bundle_d = {a_op_q, in_op, a_dst_q, in_dst, 8'h00};
                  state_d      = IDLE;
               end else begin
                  out_bundle_d = {a_op_q, a_op_q, a_dst_q, a_dst_q, 8'h00};
                  a_op_d       = in_op;
                  a_dst_d      = in_dst;
               end
            end else if (timeout && out_free) begin
               out_valid_d  = 1'b1;
               out_bundle_d = {a_op_q, a_op_q, a_dst_q, a_dst_q, 8'h00};
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_op_q       <= 8'h00;
         a_dst_q      <= 4'h0;
         out_valid_q  <= 1'b0;
         out_bundle_q <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_op_q       <= a_op_d;
         a_dst_q      <= a_dst_d;
         out_valid_q  <= out_valid_d;
         out_bundle_q <= out_bundle_d;
         err_q        <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_bundle  = out_bundle_q;
   assign err_illegal = err_q;
   assign busy        = (state_q == HOLD) || out_valid_q;

endmodule

// File: tb/tb_vliw_bundle_packer.sv
module tb_vliw_bundle_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_op;
   logic [3:0]  in_dst;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_bundle;
   logic        err_illegal;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   vliw_bundle_packer #(.FLUSH_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dst(in_dst),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
      .err_illegal(err_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] dst);
      in_valid = v;
      in_op    = op;
      in_dst   = dst;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 8'h00, 4'h0);
      #2;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bundle !== 32'h0 ||
          err_illegal !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: rdy=%b vld=%b bundle=%h err=%b busy=%b, want 0 0 00000000 0 0",
                  in_ready, out_valid, out_bundle, err_illegal, busy);
      end
      step(); step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_pair();
      drive(1'b1, 8'h00, 4'h1);
      step();
      drive(1'b1, 8'h01, 4'h2);
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pair_hold: rdy=%b busy=%b want 1 1", in_ready, busy);
      end
      step();
      drive(1'b0, 8'h00, 4'h0);
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0001_1200) begin
         miscompares++;
         $display("FAIL pair_bundle: vld=%b bundle=%h want 1 00011200", out_valid, out_bundle);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL pair_one_cycle: vld=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_conflict();
      drive(1'b1, 8'h02, 4'h5);
      step();
      drive(1'b1, 8'h03, 4'h5);
      step();
      drive(1'b0, 8'h00, 4'h0);
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0202_5500 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_single: vld=%b bundle=%h busy=%b want 1 02025500 1",
                  out_valid, out_bundle, busy);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_pending: vld=%b busy=%b want 0 1", out_valid, busy);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0303_5500) begin
         miscompares++;
         $display("FAIL conflict_drain: vld=%b bundle=%h want 1 03035500", out_valid, out_bundle);
      end
      step();
   endtask

   task automatic test_flush();
      drive(1'b1, 8'h04, 4'h7);
      step();
      flush = 1'b1;
      drive(1'b1, 8'h00, 4'h8);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_blocks_input: rdy=%b want 0", in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0404_7700 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_bundle: vld=%b bundle=%h rdy=%b want 1 04047700 1",
                  out_valid, out_bundle, in_ready);
      end
      step();
      flush = 1'b0;
      drive(1'b0, 8'h00, 4'h0);
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_next_accepted: vld=%b busy=%b want 0 1", out_valid, busy);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0000_8800) begin
         miscompares++;
         $display("FAIL flush_second: vld=%b bundle=%h want 1 00008800", out_valid, out_bundle);
      end
      step();
   endtask

   task automatic test_illegal();
      drive(1'b1, 8'h00, 4'h3);
      step();
      drive(1'b1, 8'h09, 4'h4);
      step();
      drive(1'b1, 8'h05, 4'h4);
      vectors++;
      if (err_illegal !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_pulse: err=%b vld=%b busy=%b want 1 0 1", err_illegal, out_valid, busy);
      end
      step();
      drive(1'b0, 8'h00, 4'h0);
      vectors++;
      if (err_illegal !== 1'b0 || out_valid !== 1'b1 || out_bundle !== 32'h0005_3400) begin
         miscompares++;
         $display("FAIL illegal_pair: err=%b vld=%b bundle=%h want 0 1 00053400",
                  err_illegal, out_valid, out_bundle);
      end
      step();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 8'h00, 4'h1);
      step();
      drive(1'b1, 8'h01, 4'h2);
      step();
      drive(1'b1, 8'h02, 4'h3);
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0001_1200 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first: vld=%b bundle=%h rdy=%b want 1 00011200 1",
                  out_valid, out_bundle, in_ready);
      end
      step();
      drive(1'b1, 8'h03, 4'h4);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_mid: vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      step();
      drive(1'b0, 8'h00, 4'h0);
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0203_3400) begin
         miscompares++;
         $display("FAIL b2b_second: vld=%b bundle=%h want 1 02033400", out_valid, out_bundle);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 8'h01, 4'h1);
      step();
      drive(1'b1, 8'h02, 4'h2);
      step();
      drive(1'b1, 8'h03, 4'h3);
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0102_1200 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_bundle: vld=%b bundle=%h rdy=%b want 1 01021200 1",
                  out_valid, out_bundle, in_ready);
      end
      step();
      drive(1'b1, 8'h04, 4'h4);
      step(); step();
      vectors++;
      if (in_ready !== 1'b0 || out_bundle !== 32'h0102_1200 || out_valid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_stall: rdy=%b vld=%b bundle=%h busy=%b want 0 1 01021200 1",
                  in_ready, out_valid, out_bundle, busy);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_bundle !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_reset: vld=%b bundle=%h busy=%b rdy=%b want 0 00000000 0 0",
                  out_valid, out_bundle, busy, in_ready);
      end
      drive(1'b0, 8'h00, 4'h0);
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_timeout();
      bit seen;
      drive(1'b1, 8'h01, 4'h6);
      step();
      drive(1'b0, 8'h00, 4'h0);
`ifdef VLIW_PACK_TIMEOUT_EN
      step(); step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: vld=%b want 0", out_valid);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0101_6600) begin
         miscompares++;
         $display("FAIL timeout_bundle: vld=%b bundle=%h want 1 01016600", out_valid, out_bundle);
      end
      step();
      seen = 1'b0;
`else
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL no_timeout: bundle_seen=%b busy=%b want 0 1", seen, busy);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_bundle !== 32'h0101_6600) begin
         miscompares++;
         $display("FAIL no_timeout_flush: vld=%b bundle=%h want 1 01016600", out_valid, out_bundle);
      end
      step();
`endif
   endtask

   initial begin
      test_reset();
      test_pair();
      test_conflict();
      test_flush();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
